reg_wb_queue: RTL

//  Writeback buffer directly upstream of the 32x8 dual-write register file.

---
 rtl/reg_wb_queue_pkg.sv | 12 +
 rtl/reg_wb_queue_if.sv | 31 +++
 rtl/reg_wb_queue_mem.sv | 28 ++
 rtl/reg_wb_queue.sv | 67 ++++++
 4 files changed

// File: rtl/reg_wb_queue_pkg.sv
// reg_wb_queue_pkg: shared widths, queue sizing and the writeback entry type.
package reg_wb_queue_pkg;
  localparam int DEPTH = 8;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/reg_wb_queue_if.sv
// reg_wb_queue_if: producer, register-file drain and hazard-check signals of the writeback queue.
interface reg_wb_queue_if;
  import reg_wb_queue_pkg::*;
  logic              req1_v;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req2_v;
  logic [ADDR_W-1:0] req2_addr;
  logic [DATA_W-1:0] req2_data;
  logic              req_rdy;
  logic              hold;
  logic [ADDR_W-1:0] rwdt1;
  logic [ADDR_W-1:0] rwdt2;
  logic [DATA_W-1:0] in_data1;
  logic [DATA_W-1:0] in_data2;
  logic              w_en;
  logic [ADDR_W-1:0] chk_addr1;
  logic [ADDR_W-1:0] chk_addr2;
  logic              hit1;
  logic              hit2;
  logic [CNT_W-1:0]  count;
  logic              empty;
  modport master (
    output req1_v, req1_addr, req1_data, req2_v, req2_addr, req2_data, hold, chk_addr1, chk_addr2,
    input  req_rdy, rwdt1, rwdt2, in_data1, in_data2, w_en, hit1, hit2, count, empty
  );
  modport slave (
    input  req1_v, req1_addr, req1_data, req2_v, req2_addr, req2_data, hold, chk_addr1, chk_addr2,
    output req_rdy, rwdt1, rwdt2, in_data1, in_data2, w_en, hit1, hit2, count, empty
  );
endinterface

// File: rtl/reg_wb_queue_mem.sv
// wb_queue_mem: uncleared entry storage, two write ports, head/head+1 reads, all addresses for hazard compare.
module wb_queue_mem
  import reg_wb_queue_pkg::*;
(
  input  logic              clk,
  input  logic              we1_i,
  input  logic [PTR_W-1:0]  wa1_i,
  input  wb_entry_t         wd1_i,
  input  logic              we2_i,
  input  logic [PTR_W-1:0]  wa2_i,
  input  wb_entry_t         wd2_i,
  input  logic [PTR_W-1:0]  ra1_i,
  input  logic [PTR_W-1:0]  ra2_i,
  output wb_entry_t         rd1_o,
  output wb_entry_t         rd2_o,
  output logic [ADDR_W-1:0] addr_o [DEPTH]
);
  wb_entry_t mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we1_i) mem_q[wa1_i] <= wd1_i;
    if (we2_i) mem_q[wa2_i] <= wd2_i;
  end
  assign rd1_o = mem_q[ra1_i];
  assign rd2_o = mem_q[ra2_i];
  for (genvar i = 0; i < DEPTH; i++) begin : g_addr
    assign addr_o[i] = mem_q[i].addr;
  end
endmodule

// File: rtl/reg_wb_queue.sv
// reg_wb_queue: in-order writeback queue, two enqueues and two register-file writes per cycle, RAW hit report.
module reg_wb_queue
  import reg_wb_queue_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  reg_wb_queue_if.slave  bus
);
  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        n_enq, n_deq;
  logic              acc1, acc2;
  wb_entry_t         head, next, port2;
  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DEPTH-1:0]  m1, m2;
  assign bus.req_rdy = cnt_q <= CNT_W'(DEPTH - 2);
  assign acc1 = bus.req_rdy && bus.req1_v;
  assign acc2 = bus.req_rdy && bus.req2_v;
  assign n_enq = {1'b0, acc1} + {1'b0, acc2};
  assign bus.empty = cnt_q == '0;
  assign bus.count = cnt_q;
  assign bus.w_en = !bus.empty && !bus.hold;
  assign n_deq = !bus.w_en ? 2'd0 : cnt_q >= CNT_W'(2) ? 2'd2 : 2'd1;
  // a lone entry drives both ports since the register file shares one enable
  assign port2 = cnt_q >= CNT_W'(2) ? next : head;
  assign bus.rwdt1 = head.addr;
  assign bus.in_data1 = head.data;
  assign bus.rwdt2 = port2.addr;
  assign bus.in_data2 = port2.data;
  assign cnt_d = cnt_q + CNT_W'(n_enq) - CNT_W'(n_deq);
  assign wr_d = wr_q + PTR_W'(n_enq);
  assign rd_d = rd_q + PTR_W'(n_deq);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  wb_queue_mem u_mem (
    .clk    (clk),
    .we1_i  (acc1),
    .wa1_i  (wr_q),
    .wd1_i  ({bus.req1_addr, bus.req1_data}),
    .we2_i  (acc2),
    .wa2_i  (wr_q + PTR_W'(acc1)),
    .wd2_i  ({bus.req2_addr, bus.req2_data}),
    .ra1_i  (rd_q),
    .ra2_i  (rd_q + PTR_W'(1)),
    .rd1_o  (head),
    .rd2_o  (next),
    .addr_o (ent_addr)
  );
  // slot i is live when its distance from the head is below the occupancy
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    logic [PTR_W-1:0] off;
    assign off = PTR_W'(i) - rd_q;
    assign m1[i] = ({1'b0, off} < cnt_q) && ent_addr[i] == bus.chk_addr1;
    assign m2[i] = ({1'b0, off} < cnt_q) && ent_addr[i] == bus.chk_addr2;
  end
  assign bus.hit1 = |m1 || (acc1 && bus.req1_addr == bus.chk_addr1) || (acc2 && bus.req2_addr == bus.chk_addr1);
  assign bus.hit2 = |m2 || (acc1 && bus.req1_addr == bus.chk_addr2) || (acc2 && bus.req2_addr == bus.chk_addr2);
endmodule
